// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester turning a valid/ready command into a SETUP/ACCESS transfer.
// Wait states are counted in ACCESS; if TIMEOUT is non-zero, a stuck slave is abandoned with rsp_err.
module apb_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              sel,
    output logic              enable,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    // Wide enough to hold TIMEOUT without wrapping; also valid when TIMEOUT is 0.
    localparam int CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
    logic [1:0]    r_state;
    logic [CW-1:0] r_wait;
    logic          w_timeout;
    assign req_ready = (r_state == IDLE);
    // Abort on the edge where the wait count would reach TIMEOUT; a high ready wins.
    assign w_timeout = (TIMEOUT > 0) && !ready && (r_wait == TO_LAST);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wait    <= '0;
            sel       <= 1'b0;
            enable    <= 1'b0;
            write     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (r_state == IDLE) begin
                if (req_valid) begin
                    r_state <= SETUP;
                    sel     <= 1'b1;
                    write   <= req_write;
                    addr    <= req_addr;
                    wdata   <= req_wdata;
                end
            end else if (r_state == SETUP) begin
                r_state <= ACCESS;
                enable  <= 1'b1;
                r_wait  <= '0;
            end else if (r_state == ACCESS) begin
                if (ready || w_timeout) begin
                    r_state   <= IDLE;
                    sel       <= 1'b0;
                    enable    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= !ready;
                    rsp_rdata <= (ready && !write) ? rdata : '0;
                end else begin
                    r_wait <= (r_wait == '1) ? r_wait : r_wait + 1'b1;
                end
            end else begin
                r_state <= IDLE;
                sel     <= 1'b0;
                enable  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: two DUTs (TIMEOUT 16 and 4) driven with directed and random transfers.
// Expected timing comes from wait-state count W: ACCESS lasts W+1 cycles, or TIMEOUT cycles on abort.
module tb_apb_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_write [2];
    logic [7:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        sel       [2];
    logic        enable    [2];
    logic        write     [2];
    logic [7:0]  addr      [2];
    logic [31:0] wdata     [2];
    logic [31:0] rdata     [2];
    logic        ready     [2];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .sel(sel[0]), .enable(enable[0]), .write(write[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0])
    );

    apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(4)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .sel(sel[1]), .enable(enable[1]), .write(write[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [44:0] bus(input int d);
        return {req_ready[d], rsp_valid[d], sel[d], enable[d], write[d], addr[d], wdata[d]};
    endfunction

    // Called just after a negedge with the DUT idle; returns at the negedge of the response cycle.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                        input logic [31:0] rv, input int w, input bit hold = 1'b0,
                        input bit nwr = 1'b0, input logic [7:0] na = 8'h0, input logic [31:0] nwd = 32'h0);
        int t;
        bit ab;
        int len;
        t   = (d == 1) ? 4 : 16;
        ab  = (t > 0) && (w >= t);
        len = ab ? t : w + 1;
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        ready[d]     = 1'($urandom);
        rdata[d]     = $urandom;
        chk("req_ready_idle", 64'(req_ready[d]), 64'd1);
        @(negedge clk);
        if (hold) begin
            req_write[d] = nwr;
            req_addr[d]  = na;
            req_wdata[d] = nwd;
        end else begin
            req_valid[d] = 1'b0;
        end
        ready[d] = 1'($urandom);
        rdata[d] = $urandom;
        chk("setup", 64'(bus(d)), 64'({2'b00, 2'b10, wr, a, wd}));
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            ready[d] = (k > w);
            rdata[d] = (k > w) ? rv : $urandom;
            chk("access", 64'(bus(d)), 64'({2'b00, 2'b11, wr, a, wd}));
        end
        @(negedge clk);
        chk("rsp_ctl", 64'({req_ready[d], rsp_valid[d], rsp_err[d], sel[d], enable[d]}),
            64'({1'b1, 1'b1, ab, 1'b0, 1'b0}));
        chk("rsp_rdata", 64'(rsp_rdata[d]), 64'((ab || wr) ? 32'h0 : rv));
        ready[d] = 1'($urandom);
        rdata[d] = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ready[0] = 1'($urandom);
            ready[1] = 1'($urandom);
            chk("idle", 64'({rsp_valid[0], sel[0], rsp_valid[1], sel[1]}), 64'd0);
        end
    endtask

    // Reset pulse in the w-th wait-state ACCESS cycle of DUT 0.
    task automatic rst_mid(input int w);
        req_valid[0] = 1'b1;
        req_write[0] = 1'($urandom);
        req_addr[0]  = 8'($urandom);
        req_wdata[0] = $urandom;
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int k = 1; k <= w; k++) begin
            @(negedge clk);
            ready[0] = 1'b0;
        end
        chk("pre_rst", 64'({sel[0], enable[0]}), 64'b11);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 64'({sel[0], enable[0], rsp_valid[0], req_ready[0], addr[0]}), 64'({4'b0001, 8'h00}));
        @(negedge clk);
        rst_n = 1'b1;
        ready[0] = 1'b1;
        chk("rst_rel_ready", 64'(req_ready[0]), 64'd1);
        idle(3);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_write[d] = 1'b0;
            req_addr[d]  = 8'h0;
            req_wdata[d] = 32'h0;
            rdata[d]     = 32'h0;
            ready[d]     = 1'b0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ctl", 64'({sel[d], enable[d], write[d], rsp_valid[d], rsp_err[d], req_ready[d]}), 64'b000001);
            chk("rst_data", {addr[d], wdata[d], rsp_rdata[d][23:0]}, 64'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("first_ready", 64'({req_ready[0], req_ready[1]}), 64'b11);
        xfer(0, 1'b1, 8'h10, 32'hA5A5A5A5, 32'h12345678, 0);
        idle(2);
        xfer(0, 1'b0, 8'h20, 32'h0, 32'hDEADBEEF, 5);
        idle(1);
        xfer(0, 1'b1, 8'h30, 32'h11111111, 32'h0, 2, 1'b1, 1'b0, 8'h31, 32'h22222222);
        xfer(0, 1'b0, 8'h31, 32'h22222222, 32'h55AA55AA, 1);
        idle(1);
        xfer(1, 1'b0, 8'h40, 32'h0, 32'hCAFEF00D, 50);
        xfer(1, 1'b1, 8'h41, 32'h0BADBEEF, 32'h0, 0);
        idle(1);
        xfer(1, 1'b0, 8'h42, 32'h0, 32'h13572468, 3);
        xfer(1, 1'b0, 8'h43, 32'h0, 32'h24681357, 4);
        xfer(0, 1'b0, 8'h50, 32'h0, 32'h0F0F0F0F, 15);
        xfer(0, 1'b0, 8'h51, 32'h0, 32'hF0F0F0F0, 16);
        idle(1);
        rst_mid(1);
        xfer(0, 1'b0, 8'h60, 32'h0, 32'h01010101, 1);
        rst_mid(3);
        xfer(0, 1'b1, 8'h61, 32'h02020202, 32'h0, 3);
        rst_mid(5);
        xfer(0, 1'b0, 8'h62, 32'h0, 32'h03030303, 0);
        repeat (40) begin
            xfer(int'($urandom_range(0, 1)), 1'($urandom), 8'($urandom), $urandom, $urandom,
                 int'($urandom_range(0, 20)));
            idle(int'($urandom_range(0, 2)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
